// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird game controller.
// Also holds the saturating two-digit BCD increment used for the score.
package flappy_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;

   typedef logic [15:0] column_t;

   localparam int ROWS = 16;
   localparam int COLS = 16;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] bcd);
      logic [7:0] result;
      result = bcd;
      if (bcd == 8'h99) begin
         result = bcd;
      end else if (bcd[3:0] == 4'd9) begin
         result = {bcd[7:4] + 4'd1, 4'd0};
      end else begin
         result = {bcd[7:4], bcd[3:0] + 4'd1};
      end
      return result;
   endfunction

endpackage

// File: rtl/flappy_game_ctrl_tick_gen.sv
// Free-running modulo-DIV counter; tick marks the terminal count.
// The counter advances only while run is high and returns to zero on clear.
module tick_gen #(
   parameter int DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (run) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: paces the pattern generator, scrolls the pipe buffer,
// moves the bird and keeps a saturating BCD score.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int SCROLL_DIV = 8,
   parameter int FALL_DIV   = 12,
   parameter int FLAP_H     = 2,
   parameter int BIRD_COL   = 2,
   parameter int BIRD_START = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                flap,
   input  column_t             pat_col,
   output logic                pat_enable,
   output logic                pat_reset,
   output column_t [COLS-1:0]  pipes,
   output logic [3:0]          bird_row,
   output logic [3:0]          score_tens,
   output logic [3:0]          score_ones,
   output logic                game_over
);

   game_state_t state, state_next;

   logic       scroll_tick;
   logic       fall_tick;
   logic       shift_pending;
   logic       clear_all;
   logic       playing;
   logic       hit;
   logic       floor_fall;
   logic [3:0] flap_row;
   logic [7:0] score;

   // Leaving OVER restores the idle values on the same edge that enters IDLE.
   assign clear_all  = (state == IDLE) || ((state == OVER) && start);
   assign playing    = (state == PLAY);
   assign hit        = pipes[BIRD_COL][bird_row];
   assign floor_fall = fall_tick && !flap && (bird_row == 4'd0);

   tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
      .clk   (clk),
      .reset (reset),
      .clear (clear_all),
      .run   (playing),
      .tick  (scroll_tick)
   );

   tick_gen #(.DIV(FALL_DIV)) u_fall_tick (
      .clk   (clk),
      .reset (reset),
      .clear (clear_all || (playing && flap)),
      .run   (playing),
      .tick  (fall_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pat_enable = 1'b0;
      pat_reset  = reset;
      game_over  = 1'b0;
      case (state)
         IDLE: begin
            pat_reset = 1'b1;
            if (start) begin
               state_next = PLAY;
            end
         end
         PLAY: begin
            pat_enable = scroll_tick;
            if (hit || floor_fall) begin
               state_next = OVER;
            end
         end
         OVER: begin
            game_over = 1'b1;
            if (start) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      flap_row = 4'd15;
      if (int'(bird_row) + FLAP_H < ROWS) begin
         flap_row = 4'(int'(bird_row) + FLAP_H);
      end
   end

   // Datapath only moves in PLAY; OVER freezes everything until restart.
   always_ff @(posedge clk) begin
      if (reset || clear_all) begin
         pipes         <= '0;
         bird_row      <= 4'(BIRD_START);
         score         <= 8'h00;
         shift_pending <= 1'b0;
      end else if (playing) begin
         shift_pending <= scroll_tick;
         if (shift_pending) begin
            pipes <= {pat_col, pipes[COLS-1:1]};
            if (pipes[BIRD_COL+1] != '0) begin
               score <= bcd_inc_sat(score);
            end
         end
         if (flap) begin
            bird_row <= flap_row;
         end else if (fall_tick && (bird_row != 4'd0)) begin
            bird_row <= bird_row - 4'd1;
         end
      end
   end

   assign score_tens = score[7:4];
   assign score_ones = score[3:0];

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed self-checking bench for flappy_game_ctrl with SCROLL_DIV=4, FALL_DIV=6.
// Nn below means the n-th falling edge after the PLAY entry edge (N0 = first).
module tb_flappy_game_ctrl;

   logic              clk;
   logic              reset;
   logic              start;
   logic              flap;
   logic [15:0]       pat_col;
   logic              pat_enable;
   logic              pat_reset;
   logic [15:0][15:0] pipes;
   logic [3:0]        bird_row;
   logic [3:0]        score_tens;
   logic [3:0]        score_ones;
   logic              game_over;

   int checks = 0;
   int errors = 0;

   flappy_game_ctrl #(
      .SCROLL_DIV (4),
      .FALL_DIV   (6),
      .FLAP_H     (2),
      .BIRD_COL   (2),
      .BIRD_START (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .flap       (flap),
      .pat_col    (pat_col),
      .pat_enable (pat_enable),
      .pat_reset  (pat_reset),
      .pipes      (pipes),
      .bird_row   (bird_row),
      .score_tens (score_tens),
      .score_ones (score_ones),
      .game_over  (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      flap  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Returns at N0 when called from IDLE.
   task automatic press_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      bit seen_enable = 1'b0;
      bit lost_reset  = 1'b0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         if (pat_enable !== 1'b0) seen_enable = 1'b1;
         if (pat_reset !== 1'b1) lost_reset = 1'b1;
      end
      checks++; if (seen_enable !== 1'b0) begin errors++; $display("[TB] FAIL idle_pat_enable seen high in IDLE"); end
      checks++; if (lost_reset !== 1'b0) begin errors++; $display("[TB] FAIL idle_pat_reset dropped in IDLE"); end
      checks++; if (pipes !== '0) begin errors++; $display("[TB] FAIL idle_pipes got nonzero expected 0"); end
      checks++; if (bird_row !== 4'd8) begin errors++; $display("[TB] FAIL idle_bird got %0d expected 8", bird_row); end
      checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL idle_score got %h expected 00", {score_tens, score_ones}); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL idle_game_over got %b expected 0", game_over); end
   endtask

   task automatic test_scroll();
      do_reset();
      pat_col = 16'hF03F;
      press_start();
      for (int n = 0; n <= 61; n++) begin
         checks++;
         if (pat_enable !== ((n % 4) == 3)) begin errors++; $display("[TB] FAIL scroll_pat_enable N%0d got %b expected %b", n, pat_enable, ((n % 4) == 3)); end
         if (n == 4) begin
            checks++; if (bird_row !== 4'd10) begin errors++; $display("[TB] FAIL scroll_flap_row got %0d expected 10", bird_row); end
         end
         if (n == 5) begin
            checks++; if (pipes[15] !== 16'hF03F) begin errors++; $display("[TB] FAIL scroll_col15 got %h expected f03f", pipes[15]); end
            checks++; if (pipes[14] !== 16'h0000) begin errors++; $display("[TB] FAIL scroll_col14_early got %h expected 0000", pipes[14]); end
         end
         if (n == 9) begin
            checks++; if (pipes[14] !== 16'hF03F) begin errors++; $display("[TB] FAIL scroll_col14 got %h expected f03f", pipes[14]); end
         end
         if (n == 10) begin
            checks++; if (bird_row !== 4'd9) begin errors++; $display("[TB] FAIL scroll_fall_row got %0d expected 9", bird_row); end
         end
         if (n == 53) begin
            checks++; if (pipes[3] !== 16'hF03F) begin errors++; $display("[TB] FAIL scroll_col3 got %h expected f03f", pipes[3]); end
            checks++; if (pipes[2] !== 16'h0000) begin errors++; $display("[TB] FAIL scroll_col2_early got %h expected 0000", pipes[2]); end
            checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL scroll_score_before got %h expected 00", {score_tens, score_ones}); end
         end
         if (n == 57) begin
            checks++; if (pipes[2] !== 16'hF03F) begin errors++; $display("[TB] FAIL scroll_col2 got %h expected f03f", pipes[2]); end
            checks++; if ({score_tens, score_ones} !== 8'h01) begin errors++; $display("[TB] FAIL scroll_score_first got %h expected 01", {score_tens, score_ones}); end
         end
         if (n == 61) begin
            checks++; if ({score_tens, score_ones} !== 8'h02) begin errors++; $display("[TB] FAIL scroll_score_second got %h expected 02", {score_tens, score_ones}); end
            checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL scroll_no_crash got %b expected 0", game_over); end
         end
         flap = ((n % 13) == 3);
         step();
      end
      flap = 1'b0;
   endtask

   task automatic test_gravity();
      bit seen_enable = 1'b0;
      do_reset();
      pat_col = 16'h0000;
      press_start();
      for (int n = 0; n <= 54; n++) begin
         if (n == 5 || n == 6 || n == 47 || n == 48) begin
            checks++;
            if (bird_row !== 4'(8 - n / 6)) begin errors++; $display("[TB] FAIL gravity_row N%0d got %0d expected %0d", n, bird_row, 8 - n / 6); end
         end
         if (n == 53) begin
            checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL gravity_early_over got %b expected 0", game_over); end
         end
         if (n == 54) begin
            checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL gravity_floor_over got %b expected 1", game_over); end
         end
         if (n < 54) step();
      end
      for (int i = 0; i < 50; i++) begin
         step();
         if (pat_enable !== 1'b0) seen_enable = 1'b1;
      end
      checks++; if (seen_enable !== 1'b0) begin errors++; $display("[TB] FAIL over_pat_enable seen high in OVER"); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL over_hold got %b expected 1", game_over); end
      checks++; if (bird_row !== 4'd0) begin errors++; $display("[TB] FAIL over_bird got %0d expected 0", bird_row); end
      checks++; if (pat_reset !== 1'b0) begin errors++; $display("[TB] FAIL over_pat_reset got %b expected 0", pat_reset); end
      checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL over_score got %h expected 00", {score_tens, score_ones}); end
   endtask

   task automatic test_flap();
      do_reset();
      pat_col = 16'h0000;
      press_start();
      for (int n = 0; n <= 29; n++) begin
         if (n == 3) begin
            checks++; if (bird_row !== 4'd14) begin errors++; $display("[TB] FAIL flap_climb got %0d expected 14", bird_row); end
         end
         if (n == 4 || n == 5) begin
            checks++; if (bird_row !== 4'd15) begin errors++; $display("[TB] FAIL flap_saturate N%0d got %0d expected 15", n, bird_row); end
         end
         if (n == 11) begin
            checks++; if (bird_row !== 4'd14) begin errors++; $display("[TB] FAIL flap_fall1 got %0d expected 14", bird_row); end
         end
         if (n == 17) begin
            checks++; if (bird_row !== 4'd13) begin errors++; $display("[TB] FAIL flap_fall2 got %0d expected 13", bird_row); end
         end
         if (n == 23 || n == 28) begin
            checks++; if (bird_row !== 4'd15) begin errors++; $display("[TB] FAIL flap_priority N%0d got %0d expected 15", n, bird_row); end
         end
         if (n == 29) begin
            checks++; if (bird_row !== 4'd14) begin errors++; $display("[TB] FAIL flap_next_fall got %0d expected 14", bird_row); end
         end
         flap = (n <= 4) || (n == 22);
         step();
      end
      flap = 1'b0;
   endtask

   task automatic test_collision();
      bit seen_enable = 1'b0;
      do_reset();
      pat_col = 16'hFFFF;
      press_start();
      for (int n = 0; n <= 58; n++) begin
         if (n == 56) begin
            checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL coll_early got %b expected 0", game_over); end
         end
         if (n == 57) begin
            checks++; if (pipes[2] !== 16'hFFFF) begin errors++; $display("[TB] FAIL coll_col2 got %h expected ffff", pipes[2]); end
            checks++; if (bird_row !== 4'd8) begin errors++; $display("[TB] FAIL coll_bird got %0d expected 8", bird_row); end
            checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL coll_same_cycle got %b expected 0", game_over); end
         end
         if (n == 58) begin
            checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL coll_over got %b expected 1", game_over); end
         end
         flap = (n == 3) || (n == 16) || (n == 29) || (n == 42);
         if (n < 58) step();
      end
      flap = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pat_enable !== 1'b0) seen_enable = 1'b1;
      end
      checks++; if (seen_enable !== 1'b0) begin errors++; $display("[TB] FAIL coll_pat_enable seen high in OVER"); end
      checks++; if ({score_tens, score_ones} !== 8'h01) begin errors++; $display("[TB] FAIL coll_score_frozen got %h expected 01", {score_tens, score_ones}); end
      checks++; if (bird_row !== 4'd8) begin errors++; $display("[TB] FAIL coll_bird_frozen got %0d expected 8", bird_row); end
      checks++; if (pipes[2] !== 16'hFFFF) begin errors++; $display("[TB] FAIL coll_pipes_frozen got %h expected ffff", pipes[2]); end
   endtask

   // Entered from OVER left behind by test_collision.
   task automatic test_restart();
      pat_col = 16'hF03F;
      press_start();
      checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle_over got %b expected 0", game_over); end
      checks++; if (pat_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart_idle_pat_reset got %b expected 1", pat_reset); end
      checks++; if (pipes !== '0) begin errors++; $display("[TB] FAIL restart_idle_pipes got nonzero expected 0"); end
      checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL restart_idle_score got %h expected 00", {score_tens, score_ones}); end
      checks++; if (bird_row !== 4'd8) begin errors++; $display("[TB] FAIL restart_idle_bird got %0d expected 8", bird_row); end
      step();
      checks++; if (pat_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart_still_idle got %b expected 1", pat_reset); end
      press_start();
      checks++; if (pat_reset !== 1'b0) begin errors++; $display("[TB] FAIL restart_play_pat_reset got %b expected 0", pat_reset); end
      checks++; if (pipes !== '0) begin errors++; $display("[TB] FAIL restart_clean_grid got nonzero expected 0"); end
      for (int n = 0; n <= 470; n++) begin
         if (n == 89) begin
            checks++; if ({score_tens, score_ones} !== 8'h09) begin errors++; $display("[TB] FAIL sat_score_09 got %h expected 09", {score_tens, score_ones}); end
         end
         if (n == 93) begin
            checks++; if ({score_tens, score_ones} !== 8'h10) begin errors++; $display("[TB] FAIL sat_score_10 got %h expected 10", {score_tens, score_ones}); end
         end
         if (n == 445) begin
            checks++; if ({score_tens, score_ones} !== 8'h98) begin errors++; $display("[TB] FAIL sat_score_98 got %h expected 98", {score_tens, score_ones}); end
         end
         if (n == 449 || n == 469) begin
            checks++; if ({score_tens, score_ones} !== 8'h99) begin errors++; $display("[TB] FAIL sat_score_99 N%0d got %h expected 99", n, {score_tens, score_ones}); end
         end
         if (n == 470) begin
            checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL sat_alive got %b expected 0", game_over); end
         end
         flap = ((n % 13) == 3);
         if (n < 470) step();
      end
      flap  = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (pat_reset !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pat_reset got %b expected 1", pat_reset); end
      step();
      checks++; if (pipes !== '0) begin errors++; $display("[TB] FAIL midreset_pipes got nonzero expected 0"); end
      checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL midreset_score got %h expected 00", {score_tens, score_ones}); end
      checks++; if (bird_row !== 4'd8) begin errors++; $display("[TB] FAIL midreset_bird got %0d expected 8", bird_row); end
      checks++; if (pat_enable !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pat_enable got %b expected 0", pat_enable); end
      reset = 1'b0;
      step();
      checks++; if (pat_reset !== 1'b1) begin errors++; $display("[TB] FAIL midreset_idle got %b expected 1", pat_reset); end
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      flap    = 1'b0;
      pat_col = 16'h0000;
      step();
      test_reset();
      test_scroll();
      test_gravity();
      test_flap();
      test_collision();
      test_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
